// File: rtl/bcd_pkg.sv
// Shared BCD constants and state encoding for the BCD up/down counter family.
// The state constants are also used by the incrementor-side counters.
package bcd_pkg;
  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_RUN     = ST_RUN,
    S_EXPIRED = ST_EXPIRED
  } state_t;

  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_DIGIT_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a ripple-borrow decrementer: a 0 digit with borrow wraps to 9
// and passes the borrow upward.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  input  logic                   borrow_in,
  output logic [BCD_DIGIT_W-1:0] digit_out,
  output logic                   borrow_out
);
  always_comb begin
    digit_out  = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == '0) begin
        digit_out  = BCD_DIGIT_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit - 1'b1;
      end
    end
  end
endmodule

// File: rtl/bcd_countdown.sv
// Three-digit BCD down-counter with load validation, terminal-count Done pulse
// and optional auto-reload. All outputs are registered.
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 3,
  localparam int W      = 4 * DIGITS
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Load,
  input  logic [W-1:0] LoadValue,
  input  logic         AutoReload,
  input  logic         Tick,
  output logic [W-1:0] Count,
  output logic         Running,
  output logic         Done,
  output logic         LoadError
);
  state_t       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] reload_q, reload_d;
  logic         running_q, running_d;
  logic         done_q, done_d;
  logic         lerr_q, lerr_d;

  logic [W-1:0]    dec_value;
  logic [DIGITS:0] borrow;
  logic            load_valid;
  logic            count_is_one;

  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit      (count_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .borrow_in  (borrow[g]),
      .digit_out  (dec_value[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .borrow_out (borrow[g+1])
    );
  end

  always_comb begin
    load_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(LoadValue[BCD_DIGIT_W*i +: BCD_DIGIT_W])) load_valid = 1'b0;
    end
  end

  assign count_is_one = (count_q == {{(W-BCD_DIGIT_W){1'b0}}, 4'd1});

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    lerr_d   = 1'b0;
    if (Load) begin
      if (load_valid) begin
        count_d  = LoadValue;
        reload_d = LoadValue;
        state_d  = (LoadValue == '0) ? S_IDLE : S_RUN;
      end else begin
        lerr_d = 1'b1;
      end
    end else if (state_q == S_RUN && Tick) begin
      if (count_is_one) begin
        done_d = 1'b1;
        if (AutoReload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = S_EXPIRED;
        end
      end else if (!borrow[DIGITS]) begin
        // Borrow out of the top digit means the count was 000; never wrap to 999.
        count_d = dec_value;
      end
    end
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      lerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      done_q    <= done_d;
      lerr_q    <= lerr_d;
    end
  end

  assign Count     = count_q;
  assign Running   = running_q;
  assign Done      = done_q;
  assign LoadError = lerr_q;
endmodule
